// File: rtl/pixel_frame_ctrl_pkg.sv
// pixel_ctrl_pkg: shared state encoding, default phase lengths and exposure-length helper
// for the 2x2 pixel frame sequencer.
package pixel_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READ1,
        S_WAIT1,
        S_READ2,
        S_WAIT2
    } ctrl_state_t;
    localparam int C_ERASE_DEF   = 5;
    localparam int C_EXPOSE_DEF  = 255;
    localparam int C_CONVERT_DEF = 255;
    // A requested exposure of zero selects the default length.
    function automatic logic [7:0] expose_len(input logic [7:0] req, input logic [7:0] def);
        return (req == 8'd0) ? def : req;
    endfunction
endpackage

// File: rtl/pixel_frame_ctrl_if.sv
// pixel_frame_ctrl_if: array-side strobes/ramp/pixel buses plus the row readout valid/ready channel.
// master = sequencer (drives strobes, dac_code, out_*; receives pix_a/pix_b, out_ready)
// slave  = array model + readout sink (the opposite directions)
interface pixel_frame_ctrl_if #(parameter int DW = 8);
    logic          erase;
    logic          expose;
    logic          convert;
    logic          read1;
    logic          read2;
    logic [DW-1:0] dac_code;
    logic [DW-1:0] pix_a;
    logic [DW-1:0] pix_b;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic          out_row;
    logic          out_valid;
    logic          out_ready;
    modport master (
        output erase, expose, convert, read1, read2, dac_code,
        output out_a, out_b, out_row, out_valid,
        input  pix_a, pix_b, out_ready
    );
    modport slave (
        input  erase, expose, convert, read1, read2, dac_code,
        input  out_a, out_b, out_row, out_valid,
        output pix_a, pix_b, out_ready
    );
endinterface

// File: rtl/pixel_frame_ctrl_phase_timer.sv
// phase_timer: loadable 8-bit down-counter shared by the erase, expose and convert phases.
// Ports: clk, reset (sync, active-high), load/value (reload), span (length used for the
// up-count view), done (count has reached 1, i.e. last cycle of the phase), up (span - count).
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] value,
    input  logic [7:0] span,
    output logic       done,
    output logic [7:0] up
);
    logic [7:0] count;
    always_ff @(posedge clk) begin
        if (reset)
            count <= 8'd0;
        else if (load)
            count <= value;
        else if (count != 8'd0)
            count <= count - 8'd1;
    end
    assign done = (count == 8'd1);
    // With span loaded, the first cycle reads 0 and the last reads span-1.
    assign up = span - count;
endmodule

// File: rtl/pixel_frame_ctrl.sv
// pixel_frame_ctrl: frame sequencer driving ERASE/EXPOSE/CONVERT/READ1/READ2, the conversion
// ramp, and a valid/ready hand-off of each captured pixel row.
// Ports: clk, reset (sync, active-high), start, continuous, expose_cycles (latched on start or
// continuous restart), busy, frame_cnt (completed frames, wraps), bus (array + readout channel).
module pixel_frame_ctrl #(
    parameter int C_ERASE      = pixel_ctrl_pkg::C_ERASE_DEF,
    parameter int C_EXPOSE_DEF = pixel_ctrl_pkg::C_EXPOSE_DEF,
    parameter int C_CONVERT    = pixel_ctrl_pkg::C_CONVERT_DEF,
    parameter int DW           = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [7:0]            expose_cycles,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    pixel_frame_ctrl_if.master    bus
);
    import pixel_ctrl_pkg::*;
    ctrl_state_t state, state_n;
    logic [7:0] exp_len;
    logic [7:0] load_val;
    logic [7:0] ramp;
    logic       load;
    logic       done;
    logic       hs;
    logic       relatch;
    assign hs      = bus.out_valid & bus.out_ready;
    assign relatch = (state == S_IDLE && start) || (state == S_WAIT2 && hs && continuous);
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (start) state_n = S_ERASE;
            S_ERASE:   if (done) state_n = S_EXPOSE;
            S_EXPOSE:  if (done) state_n = S_CONVERT;
            S_CONVERT: if (done) state_n = S_READ1;
            S_READ1:   state_n = S_WAIT1;
            S_WAIT1:   if (hs) state_n = S_READ2;
            S_READ2:   state_n = S_WAIT2;
            S_WAIT2:   if (hs) state_n = continuous ? S_ERASE : S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end
    always_comb begin
        bus.erase    = (state == S_ERASE);
        bus.expose   = (state == S_EXPOSE);
        bus.convert  = (state == S_CONVERT);
        bus.read1    = (state == S_READ1);
        bus.read2    = (state == S_READ2);
        bus.dac_code = (state == S_CONVERT) ? DW'(ramp) : '0;
        busy         = (state != S_IDLE);
    end
    // The timer is reloaded on every state change; only the timed phases look at it.
    assign load     = (state_n != state);
    assign load_val = (state_n == S_ERASE)  ? 8'(C_ERASE) :
                      (state_n == S_EXPOSE) ? exp_len : 8'(C_CONVERT);
    phase_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .value (load_val),
        .span  (8'(C_CONVERT)),
        .done  (done),
        .up    (ramp)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_len       <= 8'd0;
            bus.out_a     <= '0;
            bus.out_b     <= '0;
            bus.out_row   <= 1'b0;
            bus.out_valid <= 1'b0;
            frame_cnt     <= 16'd0;
        end else begin
            if (relatch)
                exp_len <= expose_len(expose_cycles, 8'(C_EXPOSE_DEF));
            if (state == S_READ1 || state == S_READ2) begin
                bus.out_a     <= bus.pix_a;
                bus.out_b     <= bus.pix_b;
                bus.out_row   <= (state == S_READ2);
                bus.out_valid <= 1'b1;
            end else if ((state == S_WAIT1 || state == S_WAIT2) && hs) begin
                bus.out_valid <= 1'b0;
            end
            if (state == S_WAIT2 && hs)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// tb_pixel_frame_ctrl: directed + randomized frame sequences checked against phase-length,
// ramp, row-order and frame-count expectations derived from the frame rules.
module tb_pixel_frame_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        continuous;
    logic [7:0]  expose_cycles;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] exp_fc;
    int          n_assert = 0;
    int          n_fail = 0;

    pixel_frame_ctrl_if #(.DW(8)) bus ();

    pixel_frame_ctrl #(
        .C_ERASE(5), .C_EXPOSE_DEF(255), .C_CONVERT(255), .DW(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .continuous    (continuous),
        .expose_cycles (expose_cycles),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {bus.erase, bus.expose, bus.convert, bus.read1, bus.read2};
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [7:0] ec);
        expose_cycles = ec;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Expects exactly n cycles of the given strobe pattern; optionally pulses start at cycle poke.
    task automatic phase(input string tag, input logic [4:0] vec, input int n, input bit ramp, input int poke);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (strobes() !== vec || bus.dac_code !== (ramp ? 8'(i) : 8'd0) || busy !== 1'b1)
                bad++;
            start = (i == poke);
            step();
        end
        start = 1'b0;
        check(tag, bad, 0);
    endtask

    task automatic idle_hold(input int n);
        int bad = 0;
        repeat (n) begin
            step();
            if (busy !== 1'b0 || strobes() !== 5'b0 || bus.dac_code !== 8'd0) bad++;
        end
        check("idle_hold", bad, 0);
    endtask

    task automatic wait_row(input string tag, input int stall, input logic row, input logic [7:0] a, input logic [7:0] b);
        int bad = 0;
        check({tag, "_data"}, {bus.out_valid, bus.out_row, bus.out_a, bus.out_b}, {1'b1, row, a, b});
        bus.out_ready = 1'b0;
        repeat (stall) begin
            step();
            bus.pix_a = rnd8();
            bus.pix_b = rnd8();
            if (strobes() !== 5'b0 || busy !== 1'b1 ||
                {bus.out_valid, bus.out_row, bus.out_a, bus.out_b} !== {1'b1, row, a, b}) bad++;
        end
        check({tag, "_hold"}, bad, 0);
        bus.out_ready = 1'b1;
    endtask

    // Called in the first erase cycle of a frame.
    task automatic frame(input logic [7:0] ec, input logic [7:0] ec_next, input bit cont,
                         input int st1, input int st2, input int poke,
                         input logic [7:0] a1, input logic [7:0] b1,
                         input logic [7:0] a2, input logic [7:0] b2);
        int l = (ec == 8'd0) ? 255 : int'(ec);
        phase("erase_len", 5'b10000, 5, 1'b0, -1);
        continuous = cont;
        expose_cycles = ec_next;
        phase("expose_len", 5'b01000, l, 1'b0, -1);
        phase("convert_ramp", 5'b00100, 255, 1'b1, poke);
        bus.pix_a = a1;
        bus.pix_b = b1;
        check("read1_strobe", strobes(), 5'b00010);
        step();
        bus.pix_a = rnd8();
        bus.pix_b = rnd8();
        wait_row("row1", st1, 1'b0, a1, b1);
        bus.pix_a = a2;
        bus.pix_b = b2;
        step();
        check("read2_strobe", {strobes(), bus.out_valid}, {5'b00001, 1'b0});
        step();
        bus.pix_a = rnd8();
        bus.pix_b = rnd8();
        wait_row("row2", st2, 1'b1, a2, b2);
        step();
        exp_fc = exp_fc + 16'd1;
        check("frame_cnt", frame_cnt, exp_fc);
        check("after_frame", {busy, strobes(), bus.out_valid},
              {cont, cont ? 5'b10000 : 5'b00000, 1'b0});
    endtask

    initial begin
        logic [7:0] e [5];
        int guard;
        reset = 1'b1;
        start = 1'b0;
        continuous = 1'b0;
        expose_cycles = 8'd0;
        bus.out_ready = 1'b1;
        bus.pix_a = 8'd0;
        bus.pix_b = 8'd0;
        exp_fc = 16'd0;
        step();
        step();
        check("reset_outputs", {busy, strobes(), bus.dac_code, bus.out_valid, bus.out_row, bus.out_a, bus.out_b}, 32'd0);
        check("reset_frame_cnt", frame_cnt, 16'd0);
        reset = 1'b0;
        idle_hold(3);

        kick(8'd10);
        frame(8'd10, 8'd10, 1'b0, 0, 0, -1, rnd8(), rnd8(), rnd8(), rnd8());
        idle_hold(4);

        kick(8'd0);
        frame(8'd0, 8'd0, 1'b0, 0, 0, -1, rnd8(), rnd8(), rnd8(), rnd8());

        kick(8'd7);
        frame(8'd7, 8'd7, 1'b0, 20, 20, -1, 8'h3C, 8'hA5, 8'h11, 8'hEE);

        kick(8'd4);
        frame(8'd4, 8'd4, 1'b0, 0, 0, 10, rnd8(), rnd8(), rnd8(), rnd8());
        idle_hold(6);

        foreach (e[i]) e[i] = 8'($urandom_range(0, 20));
        continuous = 1'b1;
        kick(e[0]);
        for (int k = 0; k < 4; k++)
            frame(e[k], e[k+1], k < 3, $urandom_range(0, 3), $urandom_range(0, 3), -1,
                  rnd8(), rnd8(), rnd8(), rnd8());
        check("cont_frames", frame_cnt, 16'd8);
        idle_hold(8);

        kick(8'd3);
        guard = 0;
        while (bus.dac_code !== 8'd100 && guard < 600) begin
            step();
            guard++;
        end
        check("reach_dac100", {bus.convert, bus.dac_code}, {1'b1, 8'd100});
        reset = 1'b1;
        step();
        check("midframe_reset", {busy, strobes(), bus.dac_code, bus.out_valid}, 15'd0);
        check("midframe_reset_cnt", frame_cnt, 16'd0);
        reset = 1'b0;
        idle_hold(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
